spart_bus_if: RTL
=================

Name: spart_bus_if

Overview:
- Bus-side responder for the SPART. It answers the processor driver's iocs/iorw/ioaddr/databus transactions.
- Holds the TX holding register, RX holding register (or RX FIFO), status flags and the 16-bit baud divisor.
- Generates the baud enable tick for the TX/RX shift cores.
- Sits between the driver bus and the serial tx/rx cores inside the SPART top.

Parameters:
- DB_RESET, 16'd325: divisor value loaded at reset (19200 baud at 100 MHz, 16x oversample).
- RX_DEPTH, 4: RX FIFO depth; used only when RX_FIFO_EN is defined; must be a power of 2.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous reset, active-low
- iocs  in  1  chip select, active-high; a transaction occurs on every clk edge where iocs=1
- iorw  in  1  1=read, 0=write
- ioaddr  in  2  00=TX/RX buffer, 01=status, 10=divisor low, 11=divisor high
- databus  inout  8  bidirectional data; driven only during reads
- rda  out  1  receive data available
- tbr  out  1  transmit buffer ready (TX holding register empty)
- tx_data  out  8  byte handed to TX core
- tx_load  out  1  one-cycle pulse: TX core captures tx_data
- tx_busy  in  1  TX core shifting
- rx_data  in  8  byte from RX core
- rx_valid  in  1  one-cycle pulse: rx_data valid
- baud_en  out  1  one-cycle oversample tick

Behaviour:
- Reset (rst=0, async): rda=0, tbr=1, tx_load=0, baud_en=0, tx_data=0, divisor=DB_RESET, baud counter=DB_RESET, RX storage empty, databus=Z.
- databus drive: combinational. Driven when iocs=1 && iorw=1, otherwise Z.
  - Read 00: RX head byte (stale value if rda=0, no side effect).
  - Read 01: {6'b0, tbr, rda}.
  - Read 10 / 11: divisor low / high byte.
- RX read consumption: a read of 00 with rda=1 pops the byte on that clk edge. rda updates on the next edge.
- Writes sample databus on the clk edge where iocs=1, iorw=0.
  - 00 with tbr=1: tx_data<=databus, tbr<=0.
  - 00 with tbr=0: write dropped; tx_data and tbr unchanged.
  - 10: divisor[7:0]<=databus.
  - 11: divisor[15:8]<=databus; baud counter reloads with the new full divisor on the same edge.
- TX handoff FSM (IDLE, LOAD):
  - IDLE->LOAD when tbr=0 && tx_busy=0.
  - In LOAD, tx_load=1 for exactly one cycle and tbr<=1; then return to IDLE.
  - A write to 00 in the LOAD cycle is accepted only on the following cycle (tbr already 1).
- RX path (no FIFO): rx_valid=1 latches rx_data and sets rda=1.
  - rx_valid while rda=1 overwrites the held byte (overrun, silent).
  - rx_valid on the same edge as a consuming read: new byte stored, rda stays 1.
- Baud generator: 16-bit down-counter decremented every clk.
  - At count 0: baud_en=1 for one cycle and counter reloads divisor.
  - Tick period = divisor+1 cycles.
  - Divisor 0 gives baud_en held high every cycle.
- Reset asserted mid-transaction or mid-LOAD: all state returns to reset values immediately; any pending tx_load is lost.

Optional Feature:
- RX_FIFO_EN defined: RX storage is an RX_DEPTH-entry circular FIFO.
  - Write/read pointers are log2(RX_DEPTH)+1 bits wide.
  - rda = not empty.
  - rx_valid when full: byte dropped and the FIFO contents stay unchanged.
  - Simultaneous push and pop when full: pop and push both happen; count unchanged.
  - Status read 01 returns {5'b0, full, tbr, rda}.
- RX_FIFO_EN undefined: single holding register with overwrite-on-overrun as above; status bit 2 reads 0.

Test Plan:
- Reset release -> rda=0, tbr=1, read 10/11 returns 8'h45/8'h01, databus Z with iocs=0.
- Write 11=8'h00 then 10=8'h04 then 11=8'h00 -> baud_en pulses every 5 cycles, one cycle wide.
- Write 00=8'hA5, tx_busy=0 -> tbr=0 one cycle, tx_load single pulse with tx_data=8'hA5, tbr back to 1. Repeat with tx_busy=1 held 10 cycles -> tx_load delayed until tx_busy falls.
- Write 00=8'h11 then 8'h22 while tbr=0 -> second write dropped; TX core sees only 8'h11.
- rx_valid with 8'h3C -> status reads 8'h03; read 00 returns 8'h3C; rda=0 next cycle. rx_valid coincident with that read (8'h7E) -> rda stays 1, next read returns 8'h7E.
- RX_FIFO_EN, RX_DEPTH=4: push 8'h01..8'h05 without reads -> status bit2=1, reads return 01,02,03,04; then rda=0.

Source files
------------

// File: rtl/spart_bus_if.sv
// spart_bus_if: bus-side responder of the SPART.
// Decodes iocs/iorw/ioaddr transactions. Holds the TX holding register, the RX
// holding register (or RX FIFO), the status flags and the 16-bit baud divisor.
// Generates the oversample baud tick for the shift cores.
// Optional feature: define RX_FIFO_EN to replace the single RX holding register
// with an RX_DEPTH-entry circular FIFO. RX_DEPTH must be a power of 2 and at least 2.
module spart_bus_if #(
    parameter logic [15:0] DB_RESET = 16'd325
`ifdef RX_FIFO_EN
    ,
    parameter int unsigned RX_DEPTH = 4
`endif
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       iocs,
    input  logic       iorw,
    input  logic [1:0] ioaddr,
    inout  logic [7:0] databus,
    output logic       rda,
    output logic       tbr,
    output logic [7:0] tx_data,
    output logic       tx_load,
    input  logic       tx_busy,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    output logic       baud_en
);

    localparam int unsigned DW = 8;
    localparam int unsigned CW = 16;

    localparam logic [1:0] ADDR_BUF  = 2'b00;
    localparam logic [1:0] ADDR_STAT = 2'b01;
    localparam logic [1:0] ADDR_DLO  = 2'b10;
    localparam logic [1:0] ADDR_DHI  = 2'b11;

    typedef enum logic {
        TX_IDLE = 1'b0,
        TX_LOAD = 1'b1
    } tx_state_e;

    // Bus decode
    logic          rd_c;
    logic          wr_c;
    logic          pop_c;
    logic          full_c;
    logic [DW-1:0] head_c;
    logic [DW-1:0] rd_data_c;

    // Divisor and baud counter
    logic [CW-1:0] div_q, div_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          baud_en_q, baud_en_d;

    // TX holding register and handoff FSM
    tx_state_e     state_q, state_d;
    logic          tbr_q, tbr_d;
    logic [DW-1:0] tx_data_q, tx_data_d;
    logic          tx_load_q, tx_load_d;

    // RX availability flag
    logic          rda_q, rda_d;

    assign rd_c  = iocs && iorw;
    assign wr_c  = iocs && !iorw;
    assign pop_c = rd_c && (ioaddr == ADDR_BUF) && rda_q;

    // Read mux; a stale head byte is returned when nothing is available
    always_comb begin
        rd_data_c = head_c;
        case (ioaddr)
            ADDR_BUF:  rd_data_c = head_c;
            ADDR_STAT: rd_data_c = {5'b0, full_c, tbr_q, rda_q};
            ADDR_DLO:  rd_data_c = div_q[7:0];
            ADDR_DHI:  rd_data_c = div_q[15:8];
            default:   rd_data_c = head_c;
        endcase
    end

    // Bus is driven only while the host is reading
    assign databus = rd_c ? rd_data_c : 8'bz;

    // Divisor byte writes
    always_comb begin
        div_d = div_q;
        if (wr_c && (ioaddr == ADDR_DLO)) begin
            div_d[7:0] = databus;
        end
        if (wr_c && (ioaddr == ADDR_DHI)) begin
            div_d[15:8] = databus;
        end
    end

    // Baud down-counter: tick at zero, reload on tick or on a divisor-high write
    always_comb begin
        baud_en_d = (cnt_q == CW'(0));
        if (wr_c && (ioaddr == ADDR_DHI)) begin
            cnt_d = {databus, div_q[7:0]};
        end else if (cnt_q == CW'(0)) begin
            cnt_d = div_q;
        end else begin
            cnt_d = cnt_q - CW'(1);
        end
    end

    // TX handoff FSM plus holding-register write; tbr re-arms as LOAD is entered
    always_comb begin
        state_d   = state_q;
        tbr_d     = tbr_q;
        tx_data_d = tx_data_q;
        tx_load_d = 1'b0;
        case (state_q)
            TX_IDLE: begin
                if (!tbr_q && !tx_busy) begin
                    state_d   = TX_LOAD;
                    tx_load_d = 1'b1;
                    tbr_d     = 1'b1;
                end
            end
            TX_LOAD: begin
                state_d = TX_IDLE;
            end
            default: begin
                state_d = TX_IDLE;
            end
        endcase
        if (wr_c && (ioaddr == ADDR_BUF) && tbr_q) begin
            tx_data_d = databus;
            tbr_d     = 1'b0;
        end
    end

    // Control and datapath registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            div_q     <= DB_RESET;
            cnt_q     <= DB_RESET;
            baud_en_q <= 1'b0;
            state_q   <= TX_IDLE;
            tbr_q     <= 1'b1;
            tx_data_q <= '0;
            tx_load_q <= 1'b0;
            rda_q     <= 1'b0;
        end else begin
            div_q     <= div_d;
            cnt_q     <= cnt_d;
            baud_en_q <= baud_en_d;
            state_q   <= state_d;
            tbr_q     <= tbr_d;
            tx_data_q <= tx_data_d;
            tx_load_q <= tx_load_d;
            rda_q     <= rda_d;
        end
    end

`ifdef RX_FIFO_EN
    localparam int unsigned AW = $clog2(RX_DEPTH);
    localparam int unsigned PW = AW + 1;

    logic [PW-1:0] wptr_q, wptr_d;
    logic [PW-1:0] rptr_q, rptr_d;
    logic [DW-1:0] mem_q [RX_DEPTH];
    logic          push_c;

    // Full when pointers match in index but differ in wrap bit
    assign full_c = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign head_c = mem_q[rptr_q[AW-1:0]];

    // A push into a full FIFO only proceeds when a pop frees a slot on the same edge
    always_comb begin
        push_c = rx_valid && (!full_c || pop_c);
        wptr_d = wptr_q + PW'(push_c);
        rptr_d = rptr_q + PW'(pop_c);
        rda_d  = (wptr_d != rptr_d);
    end

    // FIFO pointers and storage
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wptr_q <= '0;
            rptr_q <= '0;
            for (int i = 0; i < int'(RX_DEPTH); i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            if (push_c) begin
                mem_q[wptr_q[AW-1:0]] <= rx_data;
            end
        end
    end
`else
    logic [DW-1:0] rx_hold_q, rx_hold_d;

    assign full_c = 1'b0;
    assign head_c = rx_hold_q;

    // New byte always wins: overwrites on overrun and survives a coincident pop
    always_comb begin
        rx_hold_d = rx_hold_q;
        rda_d     = rda_q;
        if (rx_valid) begin
            rx_hold_d = rx_data;
            rda_d     = 1'b1;
        end else if (pop_c) begin
            rda_d = 1'b0;
        end
    end

    // RX holding register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_hold_q <= '0;
        end else begin
            rx_hold_q <= rx_hold_d;
        end
    end
`endif

    assign rda     = rda_q;
    assign tbr     = tbr_q;
    assign tx_data = tx_data_q;
    assign tx_load = tx_load_q;
    assign baud_en = baud_en_q;

endmodule
